// File: rtl/rgb8_div_sched.sv
// Round-robin scheduler that shares one external RGB8 divider among NUM_REQ requesters.
// A single operation is in flight at a time: grant, strobe, wait (bounded), respond.
module rgb8_div_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0][2:0][15:0]     req_a,
  input  logic [NUM_REQ-1:0][7:0]           req_b,
  output logic [NUM_REQ-1:0]                ack,
  output logic                              rsp_valid,
  output logic [2:0]                        rsp_id,
  output logic [2:0][7:0]                   rsp_q,
  output logic                              rsp_err,
  output logic                              div_strobe,
  output logic [2:0][15:0]                  div_a,
  output logic [7:0]                        div_b,
  input  logic                              div_valid,
  input  logic [2:0][7:0]                   div_q,
  output logic                              busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // WAIT lasts TIMEOUT-1 cycles, so a timeout response lands TIMEOUT+1 cycles after div_strobe.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                   state, state_n;
  logic [2:0]               rr_ptr, rr_n;
  logic [2:0]               win, win_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [NUM_REQ-1:0]       ack_n;
  logic                     rsp_valid_n, rsp_err_n, strobe_n, busy_n;
  logic [2:0]               rsp_id_n;
  logic [2:0][7:0]          rsp_q_n;
  logic [2:0][15:0]         div_a_n, sel_a;
  logic [7:0]               div_b_n, sel_b;
  logic                     grant, hi_found;
  logic [2:0]               gidx, hi_idx, lo_idx;

  // Rotating priority: lowest set bit at or above rr_ptr, else lowest set bit overall.
  always_comb begin
    grant    = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        grant  = 1'b1;
        lo_idx = 3'(j);
        if (3'(j) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = 3'(j);
        end
      end
    end
    gidx  = hi_found ? hi_idx : lo_idx;
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (3'(j) == gidx) begin
        sel_a = req_a[j];
        sel_b = req_b[j];
      end
    end
  end

  always_comb begin
    state_n     = state;
    rr_n        = rr_ptr;
    win_n       = win;
    cnt_n       = cnt;
    ack_n       = '0;
    rsp_valid_n = 1'b0;
    rsp_id_n    = rsp_id;
    rsp_q_n     = rsp_q;
    rsp_err_n   = rsp_err;
    strobe_n    = 1'b0;
    div_a_n     = div_a;
    div_b_n     = div_b;
    case (state)
      IDLE: begin
        if (grant) begin
          win_n   = gidx;
          div_a_n = sel_a;
          div_b_n = sel_b;
          for (int j = 0; j < NUM_REQ; j++) ack_n[j] = (3'(j) == gidx);
          if (sel_b == 8'd0) begin
            state_n   = RESP;
            rsp_q_n   = {3{8'hFF}};
            rsp_err_n = 1'b0;
          end else begin
            state_n  = ISSUE;
            strobe_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = '0;
      end
      WAIT: begin
        cnt_n = cnt + CW'(1);
        if (div_valid) begin
          state_n   = RESP;
          rsp_q_n   = div_q;
          rsp_err_n = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_n   = RESP;
          rsp_q_n   = {3{8'hFF}};
          rsp_err_n = 1'b1;
        end
      end
      RESP: begin
        state_n     = IDLE;
        rsp_valid_n = 1'b1;
        rsp_id_n    = win;
        rr_n        = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win        <= '0;
      cnt        <= '0;
      ack        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_q      <= '0;
      rsp_err    <= 1'b0;
      div_strobe <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_n;
      win        <= win_n;
      cnt        <= cnt_n;
      ack        <= ack_n;
      rsp_valid  <= rsp_valid_n;
      rsp_id     <= rsp_id_n;
      rsp_q      <= rsp_q_n;
      rsp_err    <= rsp_err_n;
      div_strobe <= strobe_n;
      div_a      <= div_a_n;
      div_b      <= div_b_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_rgb8_div_sched.sv
// Randomized bench for rgb8_div_sched: a transaction-level model predicts the winner,
// response cycle and payload of each operation; the bench also acts as the divider.
module tb_rgb8_div_sched;
  localparam int NUM = 4;
  localparam int TO  = 64;

  logic                       clk = 1'b0;
  logic                       resetn = 1'b0;
  logic [NUM-1:0]             req = '0;
  logic [NUM-1:0][2:0][15:0]  req_a = '0;
  logic [NUM-1:0][7:0]        req_b = '0;
  logic [NUM-1:0]             ack;
  logic                       rsp_valid;
  logic [2:0]                 rsp_id;
  logic [2:0][7:0]            rsp_q;
  logic                       rsp_err;
  logic                       div_strobe;
  logic [2:0][15:0]           div_a;
  logic [7:0]                 div_b;
  logic                       div_valid = 1'b0;
  logic [2:0][7:0]            div_q = '0;
  logic                       busy;

  int n_checks = 0;
  int n_errors = 0;
  int rr_m = 0;

  rgb8_div_sched #(.NUM_REQ(NUM), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q),
    .rsp_err(rsp_err), .div_strobe(div_strobe), .div_a(div_a), .div_b(div_b),
    .div_valid(div_valid), .div_q(div_q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ideal divider result for requester w: per-channel integer quotient, low 8 bits.
  function automatic logic [23:0] quot(input int w);
    logic [23:0] q;
    logic [15:0] t;
    q = '0;
    for (int c = 0; c < 3; c++) begin
      t = req_a[w][c] / {8'h00, req_b[w]};
      q[c*8 +: 8] = t[7:0];
    end
    return q;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 64'(ack), 0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 0);
    check({tag, "_rsp_id"}, 64'(rsp_id), 0);
    check({tag, "_rsp_q"}, 64'(rsp_q), 0);
    check({tag, "_div_strobe"}, 64'(div_strobe), 0);
    check({tag, "_div_a"}, 64'(div_a), 0);
    check({tag, "_div_b"}, 64'(div_b), 0);
    check({tag, "_busy"}, 64'(busy), 0);
  endtask

  // One full operation; d = divider delay after div_strobe (0 = never answers).
  task automatic op(input logic [NUM-1:0] mask, input int d, input bit hold,
                    input logic [NUM-1:0] glitch);
    int w, j, n, exp_n, strobes, ack_extra;
    bit bz, seen, use_glitch;
    logic [23:0] eq;
    logic eerr;
    w = -1;
    for (int k = 0; k < NUM; k++) begin
      j = (rr_m + k) % NUM;
      if (w < 0 && mask[j]) w = j;
    end
    bz = (req_b[w] == 8'd0);
    use_glitch = !hold && !bz && (glitch != '0);
    if (bz) begin
      exp_n = 2; eq = 24'hFFFFFF; eerr = 1'b0;
    end else if (d >= 1 && d <= TO - 1) begin
      exp_n = d + 3; eq = quot(w); eerr = 1'b0;
    end else begin
      exp_n = TO + 2; eq = 24'hFFFFFF; eerr = 1'b1;
    end
    req = mask;
    step();
    n = 1;
    check("ack", 64'(ack), 64'(1) << w);
    check("busy", 64'(busy), 1);
    check("strobe_first", 64'(div_strobe), 64'(!bz));
    if (!bz) begin
      check("div_a", 64'(div_a), 64'(req_a[w]));
      check("div_b", 64'(div_b), 64'(req_b[w]));
    end
    strobes = int'(div_strobe);
    ack_extra = 0;
    if (!hold) req = '0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      if (d > 0 && n == d + 1) begin
        div_valid = 1'b1;
        div_q = quot(w);
      end
      if (use_glitch && n == 2) req = glitch;
      if (use_glitch && n == 3) req = '0;
      step();
      n++;
      div_valid = 1'b0;
      strobes += int'(div_strobe);
      if (ack != '0) ack_extra++;
      seen = rsp_valid;
    end
    check("rsp_seen", 64'(seen), 1);
    check("rsp_cycle", 64'(n), 64'(exp_n));
    check("rsp_id", 64'(rsp_id), 64'(w));
    check("rsp_q", 64'(rsp_q), 64'(eq));
    check("rsp_err", 64'(rsp_err), 64'(eerr));
    check("strobe_count", 64'(strobes), 64'(!bz));
    check("ack_extra", 64'(ack_extra), 0);
    rr_m = (w + 1) % NUM;
    if (use_glitch) begin
      step();
      check("glitch_ack", 64'(ack), 0);
      check("glitch_busy", 64'(busy), 0);
    end
  endtask

  task automatic randomize_operands(input bit allow_zero);
    for (int r = 0; r < NUM; r++) begin
      for (int c = 0; c < 3; c++) req_a[r][c] = 16'($urandom);
      if (allow_zero && $urandom_range(0, 4) == 0) req_b[r] = 8'd0;
      else req_b[r] = 8'($urandom_range(1, 255));
    end
  endtask

  initial begin
    bit bad;
    repeat (3) step();
    check_reset_outputs("reset");
    resetn = 1'b1;
    step();

    // Worked example: requester 2, divider latency 4.
    req_a[2] = {16'h0400, 16'h0800, 16'h1000};
    req_b[2] = 8'h20;
    op(4'b0100, 4, 1'b0, '0);
    check("example_q", 64'(rsp_q), 64'h204080);

    // Zero divisor bypasses the divider.
    req_b[1] = 8'd0;
    op(4'b0010, 5, 1'b0, '0);

    for (int i = 0; i < 24; i++) begin
      randomize_operands(1'b1);
      op(NUM'($urandom_range(1, 15)), $urandom_range(1, 12), 1'b0,
         ($urandom_range(0, 2) == 0) ? NUM'($urandom_range(1, 15)) : '0);
    end

    // Timeout boundaries: never answers, answers in last WAIT cycle, answers too late.
    req_a[0] = {16'h1234, 16'h0777, 16'h00FF};
    req_b[0] = 8'h07;
    op(4'b0001, 0, 1'b0, '0);
    op(4'b0001, TO - 1, 1'b0, '0);
    op(4'b0001, TO, 1'b0, '0);

    // Reset in the middle of WAIT, then a stray divider pulse.
    req_b[3] = 8'h11;
    req = 4'b1000;
    step();
    check("mid_ack", 64'(ack), 64'h8);
    req = '0;
    repeat (3) step();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    rr_m = 0;
    step();
    resetn = 1'b1;
    step();
    div_valid = 1'b1;
    div_q = 24'h123456;
    step();
    div_valid = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      step();
      if (rsp_valid || busy || div_strobe || (ack != '0)) bad = 1'b1;
    end
    check("post_reset_quiet", 64'(bad), 0);

    // All requesters held high: grants rotate 0,1,2,3,0.
    randomize_operands(1'b1);
    for (int i = 0; i < 5; i++) op(4'hF, $urandom_range(1, 6), 1'b1, '0);
    req = '0;
    repeat (2) step();
    check("final_idle", 64'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/rgb8_div_sched.md
RGB8_DIV_SCHED -- requirements
Module: rgb8_div_sched

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one RGB8 divider (2..8).
REQ-002 Parameter: TIMEOUT, default 64, max cycles spent waiting for divider result.
REQ-003 Port: clk  input  1  clock; all state changes on rising edge.
REQ-004 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  NUM_REQ  per-requester request level.
REQ-006 Port: req_a  input  NUM_REQ x 3 x 16  per-requester channel dividends.
REQ-007 Port: req_b  input  NUM_REQ x 8  per-requester divisor.
REQ-008 Port: ack  output  NUM_REQ  one-hot, one-cycle pulse: operands captured.
REQ-009 Port: rsp_valid  output  1  one-cycle result pulse.
REQ-010 Port: rsp_id  output  3  index of requester owning rsp_q.
REQ-011 Port: rsp_q  output  3 x 8  RGB8 quotient (channel 0..2).
REQ-012 Port: rsp_err  output  1  qualifies rsp_valid: result is timeout fill.
REQ-013 Port: div_strobe  output  1  start pulse to shared divider.
REQ-014 Port: div_a  output  3 x 16  dividends to divider.
REQ-015 Port: div_b  output  8  divisor to divider.
REQ-016 Port: div_valid  input  1  divider done.
REQ-017 Port: div_q  input  3 x 8  divider quotient.
REQ-018 Port: busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-020 IDLE: req sampled only here; if any bit set, winner = first set bit at or after rr_ptr (wrapping NUM_REQ-1 -> 0); latch req_a/req_b of winner into div_a/div_b and winner index; ack[winner]=1 next cycle.
REQ-021 IDLE -> ISSUE on grant when latched b != 0; IDLE -> RESP with rsp_q = {FF,FF,FF}, rsp_err=0 when b == 0 (divider bypassed, no div_strobe).
REQ-022 ISSUE: div_strobe=1 exactly one cycle; next state WAIT, timeout counter cleared.
REQ-023 WAIT: on div_valid capture div_q into rsp_q, rsp_err=0, -> RESP; counter increments each WAIT cycle; counter reaching TIMEOUT -> RESP with rsp_q={FF,FF,FF}, rsp_err=1.
REQ-024 div_valid and timeout in same cycle: div_valid wins, rsp_err=0.
REQ-025 div_valid outside WAIT ignored.
REQ-026 RESP: rsp_valid=1 one cycle with rsp_id=winner; rr_ptr = (winner+1) mod NUM_REQ; -> IDLE.
REQ-027 Latency, non-zero b: req seen in IDLE cycle T -> ack at T+1, div_strobe at T+1, rsp_valid at T+D+3 where div_valid arrives D cycles after div_strobe (D>=1).
REQ-028 Latency, b==0: rsp_valid at T+2, ack at T+1.
REQ-029 Requester holds operands stable while req high until ack; a req still high on return to IDLE is a new request.
REQ-030 req dropped before grant: no ack, no response for that requester.
REQ-031 At most one operation outstanding; no request accepted while busy.

Reset
REQ-032 resetn low, any state: state=IDLE, rr_ptr=0, ack=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_q=0, div_strobe=0, div_a=0, div_b=0, busy=0, counter=0.
REQ-033 Reset mid-operation abandons it; no rsp_valid for the in-flight request; divider output after reset ignored until next ISSUE.

Verification
REQ-034 Single req[2], a={0x1000,0x0800,0x0400}, b=0x20, divider D=4 -> ack=0b0100 one cycle, one div_strobe, rsp_valid at T+7, rsp_id=2, rsp_q={0x80,0x40,0x20}, rsp_err=0.
REQ-035 req=0b1111 held continuously, rr_ptr=0 -> grant order 0,1,2,3,0; each rsp_id matches prior ack index; no requester granted twice before others.
REQ-036 req[1] with b=0 -> ack[1] at T+1, rsp_valid at T+2, rsp_q={FF,FF,FF}, rsp_err=0, div_strobe never asserted.
REQ-037 Divider never responds, TIMEOUT=64 -> rsp_valid 65 cycles after div_strobe, rsp_err=1, rsp_q={FF,FF,FF}; return to IDLE.
REQ-038 resetn low during WAIT, then div_valid pulse -> no rsp_valid, all outputs at reset values, next request served normally starting from requester 0.
